data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
// - Parametrised data memory for the pipelined RV32I core, sitting in the MEM stage between ALU result and writeback mux.
// - Adds byte/half/word loads and stores with sign/zero extension, misalignment detection, and a sequential clear engine replacing the per-word reset.
// - Adds a valid/ready UART debug port (read/write by word index) with a held response frame; the debug port runs only while the core is halted.
// PARAMETERS
// - DEPTH       1024  number of 32-bit words; power of two, >= 4; AW = $clog2(DEPTH)
// - DBG_ADDR_W  9     width of debug word address; upper bits above AW ignored
// - INIT_CLEAR  1     1: run clear sweep after reset; 0: skip straight to IDLE
// PORTS
// - clk            in   1   clock, rising edge
// - reset_n        in   1   asynchronous, active-low reset
// - cpu_enable     in   1   core running; debug port serviced only when 0
// - mem_read       in   1   MEM-stage load
// - mem_write      in   1   MEM-stage store
// - funct3         in   3   RV32I load/store width code
// - address        in   32  byte address
// - write_data     in   32  store data (low bits used for SB/SH)
// - read_data      out  32  extended load data (combinational)
// - misaligned     out  1   combinational: access not naturally aligned
// - busy           out  1   clear sweep in progress
// - clear_req      in   1   pulse: restart clear sweep
// - dbg_req        in   1   debug request valid
// - dbg_we         in   1   1 write, 0 read
// - dbg_addr       in   DBG_ADDR_W  debug word index
// - dbg_wdata      in   32  debug write data
// - dbg_ack        out  1   one-cycle pulse: request accepted
// - dbg_rsp_valid  out  1   read frame valid, held until dbg_rsp_ready
// - dbg_rsp_ready  in   1   consumer took frame
// - dbg_rsp_data   out  42  {1'b0, dbg_addr[8:0] zero-extended/truncated to 9, word}
// - mem0           out  32  memory[0], for board display
// BEHAVIOUR
// - Reset (reset_n=0, async): state=CLEAR (INIT_CLEAR=1) or IDLE; clr_cnt=0; busy=INIT_CLEAR; dbg_ack=0; dbg_rsp_valid=0; dbg_rsp_data=0. Array contents not reset directly.
// - FSM states: CLEAR, IDLE, RSP_HOLD.
// - CLEAR: writes 0 to word clr_cnt each cycle, clr_cnt++; at clr_cnt==DEPTH-1 write then -> IDLE, busy=0 next cycle. Sweep = DEPTH cycles. CPU stores and debug requests ignored; read_data=0.
// - clear_req in IDLE or RSP_HOLD -> CLEAR, clr_cnt=0, pending frame dropped (dbg_rsp_valid=0). clear_req during CLEAR restarts at 0.
// - Index = address[AW+1:2]; byte offset = address[1:0]; address bits above AW+1 ignored (wrap).
// - Misaligned: half with address[0]=1, word with address[1:0]!=0. Misaligned store performs no write; misaligned load returns 0. Flag valid whenever mem_read|mem_write.
// - Loads (comb): LB/LBU select byte lane offset, LH/LHU lane offset[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word. mem_read=0 or undefined funct3 -> 0.
// - Stores (sync): SB/SH/SW write byte lanes via 4-bit strobe; other lanes unchanged. Undefined funct3 -> no write.
// - Load of address stored in same cycle returns old data (write at clock edge).
// - Debug (IDLE, cpu_enable=0, dbg_req=1): accepted in one cycle, dbg_ack=1 for that cycle. Write: word stored at dbg_addr[AW-1:0]. Read: frame registered, dbg_rsp_valid=1, -> RSP_HOLD.
// - RSP_HOLD: frame and valid stable; dbg_rsp_ready=1 -> valid=0, IDLE next cycle. New dbg_req not accepted (no ack) until IDLE.
// - Priority in IDLE: mem_write (aligned) beats debug; debug request with cpu_enable=1 is held off, not dropped (no ack).
// - Frame MSB always 0; address field = dbg_addr[8:0] if DBG_ADDR_W>=9 else zero-extended.
// STRUCTURE
// - Shared package dmem_pkg: funct3 constants (F3_LB..F3_SW), state enum, DBG_FRAME_W=42.
// - Sub-module lsu_align: combinational lane select, strobe generation, extension and misaligned decode; array + FSM stay in top.
// TESTING
// - Reset, INIT_CLEAR=1, DEPTH=16: busy=1 for exactly 16 cycles, then every word reads 0; mem0=0.
// - SW 0xDEADBEEF @0x8; SB 0x11 @0x9; LW @0x8 -> 0xDEAD11EF; LB @0x8 -> 0xFFFFFFEF; LHU @0xA -> 0x0000DEAD.
// - SH @0x3 -> misaligned=1, word unchanged; LW @0x6 -> misaligned=1, read_data=0.
// - cpu_enable=0, debug write idx 5 = 0x12345678, then read idx 5 with ready low 3 cycles -> valid held, frame 0x005_12345678 ({0,9'd5,data}), clears one cycle after ready.
// - clear_req while in RSP_HOLD -> valid drops, busy=1, store during sweep ignored, word 5 = 0 after.
// - reset_n asserted mid-sweep and mid-RSP_HOLD -> outputs return to reset values immediately, sweep restarts from 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data memory controller.
// Contents:
//   F3_*         RV32I load/store width codes (funct3)
//   DBG_FRAME_W  width of the debug read-response frame
//   state_t      controller FSM states
package dmem_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam int DBG_FRAME_W = 42;
    typedef enum logic [1:0] {CLEAR, IDLE, RSP_HOLD} state_t;
endpackage

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: debug port bundle (UART bridge side).
// Signals:
//   dbg_req/dbg_we/dbg_addr/dbg_wdata  request from the debug master
//   dbg_ack                            one-cycle accept pulse
//   dbg_rsp_valid/ready/data           held read-response frame
// Modports: master (debug bridge), slave (memory controller).
interface data_memory_ctrl_if #(parameter int DBG_ADDR_W = 9) ();
    import dmem_pkg::*;
    logic                   dbg_req;
    logic                   dbg_we;
    logic [DBG_ADDR_W-1:0]  dbg_addr;
    logic [31:0]            dbg_wdata;
    logic                   dbg_ack;
    logic                   dbg_rsp_valid;
    logic                   dbg_rsp_ready;
    logic [DBG_FRAME_W-1:0] dbg_rsp_data;
    modport master (output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rsp_ready,
                    input  dbg_ack, dbg_rsp_valid, dbg_rsp_data);
    modport slave  (input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rsp_ready,
                    output dbg_ack, dbg_rsp_valid, dbg_rsp_data);
endinterface

// File: rtl/data_memory_ctrl_lsu_align.sv
// lsu_align: combinational load/store lane handling for one 32-bit word.
// Ports:
//   mem_read, mem_write, funct3, offset  access type and byte offset
//   word_in                              addressed memory word
//   write_data                           store data (low bits for SB/SH)
//   read_data                            extended load result (0 if none/misaligned)
//   misaligned                           access not naturally aligned
//   strobe, wdata_lane                   byte-write enables and lane-replicated data
module lsu_align
    import dmem_pkg::*;
(
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_lane
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        is_half;
    logic        is_word;
    always_comb begin
        b          = word_in[8*offset +: 8];
        h          = offset[1] ? word_in[31:16] : word_in[15:0];
        is_half    = funct3[1:0] == 2'b01;
        is_word    = funct3 == F3_LW;
        misaligned = (mem_read || mem_write) && ((is_half && offset[0]) || (is_word && offset != 2'b00));
        read_data  = (!mem_read || misaligned) ? 32'b0 :
                     funct3 == F3_LB  ? {{24{b[7]}}, b} :
                     funct3 == F3_LBU ? {24'b0, b} :
                     funct3 == F3_LH  ? {{16{h[15]}}, h} :
                     funct3 == F3_LHU ? {16'b0, h} :
                     funct3 == F3_LW  ? word_in : 32'b0;
        strobe     = (!mem_write || misaligned) ? 4'b0000 :
                     funct3 == F3_SB ? 4'b0001 << offset :
                     funct3 == F3_SH ? (offset[1] ? 4'b1100 : 4'b0011) :
                     funct3 == F3_SW ? 4'b1111 : 4'b0000;
        // Replicate narrow data across lanes so the strobe alone picks the target bytes.
        wdata_lane = funct3 == F3_SB ? {4{write_data[7:0]}} :
                     funct3 == F3_SH ? {2{write_data[15:0]}} : write_data;
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: MEM-stage data memory with byte/half/word access, clear sweep and debug port.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cpu_enable                    core running; debug port serviced only when low
//   mem_read, mem_write, funct3   MEM-stage load/store control
//   address, write_data           byte address and store data
//   read_data, misaligned         combinational load result and alignment flag
//   busy, clear_req               clear sweep status and restart pulse
//   dbg                           debug request/response bundle (slave side)
//   mem0                          word 0 for board display
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DBG_ADDR_W = 9,
    parameter int INIT_CLEAR = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_enable,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [2:0]              funct3,
    input  logic [31:0]             address,
    input  logic [31:0]             write_data,
    output logic [31:0]             read_data,
    output logic                    misaligned,
    output logic                    busy,
    input  logic                    clear_req,
    data_memory_ctrl_if.slave       dbg,
    output logic [31:0]             mem0
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] idx;
    logic [AW-1:0] dbg_idx;
    logic [8:0]    dbg_a9;
    logic [31:0]   lsu_rd;
    logic [31:0]   wlane;
    logic [3:0]    strb;
    logic          st_en;
    logic          dbg_go;
    logic          unused_addr;
    assign idx         = address[AW+1:2];
    assign unused_addr = ^address[31:AW+2];
    // Debug index and frame address field are zero-extended or truncated as widths require.
    assign dbg_idx     = AW'({{AW{1'b0}}, dbg.dbg_addr});
    assign dbg_a9      = 9'({9'b0, dbg.dbg_addr});
    assign st_en       = state != CLEAR && strb != 4'b0000;
    // A real CPU store and a clear request both win over a debug request in the same cycle.
    assign dbg_go      = state == IDLE && !cpu_enable && dbg.dbg_req && !st_en && !clear_req;
    assign read_data   = state == CLEAR ? 32'b0 : lsu_rd;
    assign mem0        = mem[0];
    lsu_align u_lsu (
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .offset     (address[1:0]),
        .word_in    (mem[idx]),
        .write_data (write_data),
        .read_data  (lsu_rd),
        .misaligned (misaligned),
        .strobe     (strb),
        .wdata_lane (wlane)
    );
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (st_en) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end else if (dbg_go && dbg.dbg_we) begin
            mem[dbg_idx] <= dbg.dbg_wdata;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= INIT_CLEAR != 0 ? CLEAR : IDLE;
            clr_cnt            <= '0;
            busy               <= INIT_CLEAR != 0;
            dbg.dbg_ack        <= 1'b0;
            dbg.dbg_rsp_valid  <= 1'b0;
            dbg.dbg_rsp_data   <= '0;
        end else begin
            dbg.dbg_ack <= dbg_go;
            if (clear_req) begin
                state             <= CLEAR;
                clr_cnt           <= '0;
                busy              <= 1'b1;
                dbg.dbg_rsp_valid <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == AW'(DEPTH - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    IDLE: if (dbg_go && !dbg.dbg_we) begin
                        dbg.dbg_rsp_data  <= {1'b0, dbg_a9, mem[dbg_idx]};
                        dbg.dbg_rsp_valid <= 1'b1;
                        state             <= RSP_HOLD;
                    end
                    RSP_HOLD: if (dbg.dbg_rsp_ready) begin
                        dbg.dbg_rsp_valid <= 1'b0;
                        state             <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
